// File: rtl/round_report_tx.sv
// round_report_tx: measures buzzer reaction time in milliseconds and reports
// each finished round to the host as a 5-byte 8N1 UART packet, LSB first.
// Packet: A5, player id (01/02), time[15:8], time[7:0], xor of bytes 1..3.
module round_report_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int MS_DIV = CLK_HZ / 1000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        round_start,
  input  logic        win_valid,
  input  logic        win_player,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] timing_ms
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BIT_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PRE_W        = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(MS_DIV - 1);
  localparam logic [3:0]           STOP_SLOT = 4'd9;   // slot 0 start, 1..8 data, 9 stop
  localparam logic [2:0]           LAST_BYTE = 3'd4;
  localparam logic [7:0]           SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SEND, S_DONE} state_t;

  state_t               state, state_d;

  // Reaction timer
  logic [PRE_W-1:0]     pre_cnt;
  logic [15:0]          ms_cnt;
  logic                 pre_wrap;
  logic [15:0]          ms_now;      // count including this cycle's tick, saturated
  logic                 win_accept;
  logic                 timer_clear;

  // Packet and bit sequencer
  logic [4:0][7:0]      pkt, pkt_d;
  logic [7:0]           player_id;
  logic [BIT_CNT_W-1:0] clk_cnt, clk_cnt_d;
  logic [3:0]           slot, slot_d;
  logic [2:0]           byte_idx, byte_d;
  logic                 frame_end;
  logic [7:0]           byte_sel;
  logic [2:0]           data_idx;

  // Registered output next values
  logic                 tx_d, busy_d, done_d;

  assign win_accept  = (state == S_ARMED) && win_valid;
  assign timer_clear = round_start && ((state == S_IDLE) || ((state == S_ARMED) && !win_valid));
  assign pre_wrap    = (pre_cnt == PRE_LAST);
  assign ms_now      = (pre_wrap && (ms_cnt != 16'hFFFF)) ? ms_cnt + 16'd1 : ms_cnt;
  assign frame_end   = (state == S_SEND) && (clk_cnt == BIT_LAST) &&
                       (slot == STOP_SLOT) && (byte_idx == LAST_BYTE);

  assign player_id   = win_player ? 8'h02 : 8'h01;
  assign pkt_d[0]    = SYNC_BYTE;
  assign pkt_d[1]    = player_id;
  assign pkt_d[2]    = ms_now[15:8];
  assign pkt_d[3]    = ms_now[7:0];
  assign pkt_d[4]    = player_id ^ ms_now[15:8] ^ ms_now[7:0];

  // State register
  always_ff @(posedge CLOCK_50) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values, independent of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic: arm on round_start, send on win, one DONE cycle
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state;
    case (state)
      S_IDLE:  if (round_start) state_d = S_ARMED;
      S_ARMED: if (win_valid)   state_d = S_SEND;
      S_SEND:  if (frame_end)   state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Bit sequencer next values: cycle-in-bit, bit slot, byte index
  always_comb begin
    clk_cnt_d = '0;
    slot_d    = '0;
    byte_d    = '0;
    if (state == S_SEND) begin
      if (clk_cnt == BIT_LAST) begin
        if (slot == STOP_SLOT) begin
          byte_d = byte_idx + 3'd1;
        end else begin
          slot_d = slot + 4'd1;
          byte_d = byte_idx;
        end
      end else begin
        clk_cnt_d = clk_cnt + 1'b1;
        slot_d    = slot;
        byte_d    = byte_idx;
      end
    end
  end

  // Output logic: line level, busy and done for the coming cycle
  always_comb begin
    case (byte_d)
      3'd0:    byte_sel = pkt[0];
      3'd1:    byte_sel = pkt[1];
      3'd2:    byte_sel = pkt[2];
      3'd3:    byte_sel = pkt[3];
      3'd4:    byte_sel = pkt[4];
      default: byte_sel = 8'hFF;
    endcase
    data_idx = 3'(slot_d - 4'd1);
    tx_d     = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_SEND: begin
        busy_d = 1'b1;
        if (slot_d == 4'd0)           tx_d = 1'b0;
        else if (slot_d == STOP_SLOT) tx_d = 1'b1;
        else                          tx_d = byte_sel[data_idx];
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers: no combinational path from inputs to pins
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tx   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tx   <= tx_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Datapath: ms timer, latched result and packet, sequencer counters
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre_cnt   <= '0;
      ms_cnt    <= '0;
      timing_ms <= '0;
      pkt       <= '0;
      clk_cnt   <= '0;
      slot      <= '0;
      byte_idx  <= '0;
    end else begin
      clk_cnt  <= clk_cnt_d;
      slot     <= slot_d;
      byte_idx <= byte_d;
      if (timer_clear) begin
        pre_cnt <= '0;
        ms_cnt  <= '0;
      end else if (state == S_ARMED) begin
        pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
        ms_cnt  <= ms_now;
      end
      if (win_accept) begin
        timing_ms <= ms_now;
        pkt       <= pkt_d;
      end
    end
  end

endmodule

// File: tb/tb_round_report_tx.sv
// tb_round_report_tx: directed bench for round_report_tx with
// CLK_HZ=1000, BAUD=100 (10 clocks per bit), MS_DIV=1 (one ms per clock).
module tb_round_report_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        round_start;
  logic        win_valid;
  logic        win_player;
  logic        tx;
  logic        busy;
  logic        done;
  logic [15:0] timing_ms;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int bad;

  round_report_tx #(
    .CLK_HZ (1000),
    .BAUD   (100),
    .MS_DIV (1)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .round_start (round_start),
    .win_valid   (win_valid),
    .win_player  (win_player),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .timing_ms   (timing_ms)
  );

  always #5 clk = ~clk;

  // done pulses counted mid-cycle, away from the active edge
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // round_start in cycle T, win in cycle T+k; returns positioned in T+k+1
  task automatic start_round(input int k, input logic player);
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
    repeat (k - 1) tick();
    win_valid  = 1'b1;
    win_player = player;
    tick();
    win_valid  = 1'b0;
  endtask

  // Called in the first cycle of the start bit of byte0. Samples each bit
  // mid-slot; optionally pulses win_valid/round_start during byte1.
  task automatic recv_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                             input bit inject);
    logic [7:0] exp_b [0:4];
    logic [9:0] frame;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3; exp_b[4] = b4;
    for (int b = 0; b < 5; b++) begin
      frame = '0;
      for (int s = 0; s < 10; s++) begin
        repeat (5) tick();
        frame[s] = tx;
        if (inject && b == 1 && s == 3) begin
          round_start = 1'b1;
          win_valid   = 1'b1;
          win_player  = 1'b1;
        end
        tick();
        round_start = 1'b0;
        win_valid   = 1'b0;
        repeat (4) tick();
      end
      check($sformatf("%s_byte%0d", tag, b), {22'b0, frame}, {22'b0, 1'b1, exp_b[b], 1'b0});
    end
  endtask

  // Called in the cycle right after the last stop bit
  task automatic finish_packet(input string tag);
    check({tag, "_done"},      {31'b0, done}, 32'd1);
    check({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done_tx"},   {31'b0, tx},   32'd1);
    tick();
    exp_done++;
    check({tag, "_done_low"},  {31'b0, done}, 32'd0);
    check({tag, "_done_cnt"},  done_cnt,      exp_done);
  endtask

  initial begin
    reset       = 1'b1;
    round_start = 1'b0;
    win_valid   = 1'b0;
    win_player  = 1'b0;

    // Reset held 3 cycles
    repeat (3) tick();
    check("rst_tx",     {31'b0, tx},     32'd1);
    check("rst_busy",   {31'b0, busy},   32'd0);
    check("rst_done",   {31'b0, done},   32'd0);
    check("rst_timing", {16'b0, timing_ms}, 32'd0);
    reset = 1'b0;
    tick();

    // Win without a round: ignored for 1000 cycles
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    bad = 0;
    repeat (1000) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("nowin_line",   bad, 0);
    check("nowin_timing", {16'b0, timing_ms}, 32'd0);

    // Player B wins 300 ms after round_start
    start_round(300, 1'b1);
    check("r300_timing", {16'b0, timing_ms}, 32'h012C);
    check("r300_busy",   {31'b0, busy},      32'd1);
    recv_packet("r300", 8'hA5, 8'h02, 8'h01, 8'h2C, 8'h2F, 1'b0);
    finish_packet("r300");

    // Player A wins after 70000 ms: timer saturates
    start_round(70000, 1'b0);
    check("sat_timing", {16'b0, timing_ms}, 32'hFFFF);
    recv_packet("sat", 8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h01, 1'b0);
    finish_packet("sat");

    // Inputs pulsed during SEND are ignored and not queued
    start_round(5, 1'b0);
    check("inj_timing", {16'b0, timing_ms}, 32'd5);
    recv_packet("inj", 8'hA5, 8'h01, 8'h00, 8'h05, 8'h04, 1'b1);
    finish_packet("inj");
    win_valid  = 1'b1;
    win_player = 1'b1;
    tick();
    win_valid = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    check("inj_no_queue", bad, 0);

    // Second round after the ignored pulses
    start_round(20, 1'b1);
    check("r20_timing", {16'b0, timing_ms}, 32'h0014);
    recv_packet("r20", 8'hA5, 8'h02, 8'h00, 8'h14, 8'h16, 1'b0);
    finish_packet("r20");

    // Reset in the middle of byte3
    start_round(10, 1'b0);
    check("abort_timing", {16'b0, timing_ms}, 32'd10);
    repeat (345) tick();
    reset = 1'b1;
    tick();
    check("abort_tx",     {31'b0, tx},   32'd1);
    check("abort_busy",   {31'b0, busy}, 32'd0);
    check("abort_done",   {31'b0, done}, 32'd0);
    check("abort_timing_rst", {16'b0, timing_ms}, 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (600) begin
      tick();
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("abort_quiet",    bad, 0);
    check("abort_done_cnt", done_cnt, exp_done);

    // Fresh round after the abort
    start_round(7, 1'b1);
    check("r7_timing", {16'b0, timing_ms}, 32'd7);
    recv_packet("r7", 8'hA5, 8'h02, 8'h00, 8'h07, 8'h05, 1'b0);
    finish_packet("r7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_report_tx.md
# round_report_tx

Reports each finished buzzer round to the external host over a UART line on a GPIO pin. It measures reaction time in milliseconds from the end of the countdown (`round_start`) to the first winning key press (`win_valid`). It then serialises a fixed 5-byte result packet, 8N1, LSB first. It sits beside the countdown/buzzer logic in the top level and is the transmit end of the host link that also carries the round-start trigger.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_HZ/BAUD`, integer truncation (434 at defaults)
- `MS_DIV`, `CLK_HZ/1000`, clock cycles per millisecond tick
- `CLOCK_50` in 1: sole clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `round_start` in 1: one-cycle pulse when the countdown reaches zero; arms the timer.
- `win_valid` in 1: one-cycle pulse on the first key press of the round.
- `win_player` in 1: winner, qualified by `win_valid`. 0 = player A (KEY3, red), 1 = player B (KEY2, blue).
- `tx` out 1: UART line; idles high.
- `busy` out 1: high while a packet is being sent.
- `done` out 1: one-cycle pulse after the last stop bit.
- `timing_ms` out 16: reaction time latched at the accepted win.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `timing_ms`=0, state IDLE, ms counter 0, prescaler 0.
- States:
  - IDLE → ARMED on `round_start`.
  - ARMED → SEND on `win_valid`.
  - SEND (per byte: START, DATA×8, STOP) → DONE after byte 4.
  - DONE → IDLE, one cycle.
- ARMED behaviour:
  - The prescaler counts 0..MS_DIV-1; on wrap, the ms counter increments.
  - The ms counter saturates at 0xFFFF and does not wrap.
  - `round_start` in ARMED clears both counters (restart).
- Accepting a win in ARMED:
  - Latch `timing_ms` = ms counter value in that cycle.
  - Latch the player.
  - Build the packet.
- Packet, in order:
  - byte0 = 0xA5 (sync)
  - byte1 = 0x01 (player A) or 0x02 (player B)
  - byte2 = `timing_ms[15:8]`
  - byte3 = `timing_ms[7:0]`
  - byte4 = byte1 ^ byte2 ^ byte3
- Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Bytes are sent back-to-back with no idle gap.
- Ignored inputs:
  - `win_valid` in IDLE, SEND or DONE.
  - `round_start` in SEND or DONE.
  - No queueing of either.
- `round_start` and `win_valid` in the same cycle in ARMED: the win is accepted using the current count; `round_start` is dropped.
- `win_player` is sampled only in the accepting cycle. Later changes do not affect the packet.
- `timing_ms` holds its value until the next accepted win or reset.
- Reset mid-packet: `tx`=1 and `busy`=0 from the next cycle. No `done` pulse; the partial packet is abandoned.

## Timing
- Win accepted in cycle N → `busy`=1 and `tx`=0 (start bit of byte0) from cycle N+1.
- A packet lasts 50·`CLKS_PER_BIT` cycles: cycles N+1 .. N+50·`CLKS_PER_BIT`.
- `done`=1 and `busy`=0 in cycle N+50·`CLKS_PER_BIT`+1; `tx` stays high.
- The block is back in IDLE in the following cycle; `round_start` is accepted from then on.
- `round_start` in cycle T sets the ms counter to 0 in T+1. With `MS_DIV`=1, a win in cycle T+k latches k (saturated).
- All outputs are registered; no combinational input-to-output paths.

## Test plan
Bench parameters: `CLK_HZ`=1000, `BAUD`=100 (`CLKS_PER_BIT`=10), `MS_DIV`=1.
- Reset held for 3 cycles → `tx`=1, `busy`=0, `done`=0, `timing_ms`=0.
- `round_start` at T, `win_valid` with `win_player`=1 at T+300 → `timing_ms`=0x012C. Line carries bytes A5 02 01 2C 2F. `tx` falls at T+301; `done` pulses at T+801.
- `win_valid` with no prior `round_start`, held off for 1000 cycles → `tx` stays 1, `busy` stays 0, `timing_ms` stays 0.
- `round_start`, then a player-A win at T+70000 → `timing_ms`=0xFFFF. Bytes A5 01 FF FF 01.
- During SEND, pulse `win_valid` (player B) and `round_start` → packet bytes unchanged and a single `done`. A new round then produces a correct second packet.
- Assert `reset` in the middle of byte3 → `tx`=1 and `busy`=0 next cycle, no `done`. A fresh round afterwards sends a full, correct packet.
